// File: rtl/kryssprodukt.sv
// rtl/kryssprodukt.sv - sequential 3-D cross product with homogeneous 4th component
// One shared W x W signed multiplier, one product per cycle, registered results.
module kryssprodukt #(
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic signed [W-1:0] a1,
  input  logic signed [W-1:0] a2,
  input  logic signed [W-1:0] a3,
  input  logic signed [W-1:0] a4,
  input  logic signed [W-1:0] b1,
  input  logic signed [W-1:0] b2,
  input  logic signed [W-1:0] b3,
  input  logic signed [W-1:0] b4,
  output logic                busy,
  output logic                done,
  output logic signed [W-1:0] c1,
  output logic signed [W-1:0] c2,
  output logic signed [W-1:0] c3,
  output logic signed [W-1:0] c4,
  output logic [3:0]          ovf
);

  localparam int AW = 2 * W + 1;

  typedef enum logic [3:0] {
    IDLE, MUL0, MUL1, MUL2, MUL3, MUL4, MUL5, MUL6, FIN
  } state_t;

  state_t state;

  logic signed [W-1:0]    ra1, ra2, ra3, ra4, rb1, rb2, rb3, rb4;
  logic signed [AW-1:0]   acc1, acc2, acc3, acc4;
  logic signed [W-1:0]    ma, mb;
  logic signed [2*W-1:0]  prod;
  logic signed [AW-1:0]   prod_x;

  // Operand selection follows the product order a2b3, a3b2, a3b1, a1b3, a1b2, a2b1, a4b4.
  always_comb begin
    ma = '0;
    mb = '0;
    case (state)
      MUL0: begin ma = ra2; mb = rb3; end
      MUL1: begin ma = ra3; mb = rb2; end
      MUL2: begin ma = ra3; mb = rb1; end
      MUL3: begin ma = ra1; mb = rb3; end
      MUL4: begin ma = ra1; mb = rb2; end
      MUL5: begin ma = ra2; mb = rb1; end
      MUL6: begin ma = ra4; mb = rb4; end
      default: begin ma = '0; mb = '0; end
    endcase
  end

  assign prod   = ma * mb;
  assign prod_x = {prod[2*W-1], prod};

  // Exact value fits in W bits only when its top AW-W+1 bits are all equal.
  function automatic logic out_of_range(input logic signed [AW-1:0] v);
    return !((&v[AW-1:W-1]) || (~|v[AW-1:W-1]));
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      c1    <= '0;
      c2    <= '0;
      c3    <= '0;
      c4    <= '0;
      ovf   <= '0;
      ra1   <= '0; ra2 <= '0; ra3 <= '0; ra4 <= '0;
      rb1   <= '0; rb2 <= '0; rb3 <= '0; rb4 <= '0;
      acc1  <= '0; acc2 <= '0; acc3 <= '0; acc4 <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ra1  <= a1; ra2 <= a2; ra3 <= a3; ra4 <= a4;
            rb1  <= b1; rb2 <= b2; rb3 <= b3; rb4 <= b4;
            acc1 <= '0; acc2 <= '0; acc3 <= '0; acc4 <= '0;
            busy <= 1'b1;
            state <= MUL0;
          end
        end
        MUL0: begin acc1 <= acc1 + prod_x; state <= MUL1; end
        MUL1: begin acc1 <= acc1 - prod_x; state <= MUL2; end
        MUL2: begin acc2 <= acc2 + prod_x; state <= MUL3; end
        MUL3: begin acc2 <= acc2 - prod_x; state <= MUL4; end
        MUL4: begin acc3 <= acc3 + prod_x; state <= MUL5; end
        MUL5: begin acc3 <= acc3 - prod_x; state <= MUL6; end
        MUL6: begin acc4 <= prod_x;        state <= FIN;  end
        FIN: begin
          c1    <= acc1[W-1:0];
          c2    <= acc2[W-1:0];
          c3    <= acc3[W-1:0];
          c4    <= acc4[W-1:0];
          ovf   <= {out_of_range(acc4), out_of_range(acc3),
                    out_of_range(acc2), out_of_range(acc1)};
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kryssprodukt.sv
// tb/tb_kryssprodukt.sv - self-checking bench for kryssprodukt
// Directed vector table, random operands against an integer model, and timing corner sequences.
module tb_kryssprodukt;

  logic clk = 1'b0;
  logic rst, start;
  logic signed [7:0] a1, a2, a3, a4, b1, b2, b3, b4;
  logic busy, done;
  logic signed [7:0] c1, c2, c3, c4;
  logic [3:0] ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  kryssprodukt #(.W(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a1(a1), .a2(a2), .a3(a3), .a4(a4),
    .b1(b1), .b2(b2), .b3(b3), .b4(b4),
    .busy(busy), .done(done),
    .c1(c1), .c2(c2), .c3(c3), .c4(c4), .ovf(ovf)
  );

  typedef struct {
    logic [7:0] a1, a2, a3, a4, b1, b2, b3, b4;
    logic [7:0] c1, c2, c3, c4;
    logic [3:0] ovf;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: exact integer arithmetic, wrap to 8 bits, range test on the full value.
  task automatic model(input int x1, x2, x3, x4, y1, y2, y3, y4, output logic [35:0] res);
    int e[4];
    logic [3:0] o;
    logic [31:0] t;
    e[0] = x2 * y3 - x3 * y2;
    e[1] = x3 * y1 - x1 * y3;
    e[2] = x1 * y2 - x2 * y1;
    e[3] = x4 * y4;
    res = '0;
    for (int i = 0; i < 4; i++) begin
      o[i] = (e[i] < -128) || (e[i] > 127);
      t = e[i];
      res[8*i +: 8] = t[7:0];
    end
    res[35:32] = o;
  endtask

  function automatic logic [35:0] outs();
    return {ovf, c4, c3, c2, c1};
  endfunction

  task automatic drive(input logic [7:0] x1, x2, x3, x4, y1, y2, y3, y4);
    a1 = x1; a2 = x2; a3 = x3; a4 = x4;
    b1 = y1; b2 = y2; b3 = y3; b4 = y4;
  endtask

  // Called just after an edge: pulses start for the next edge (N), returns edges from N until done.
  task automatic launch_and_wait(output int lat);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
  endtask

  logic [35:0] exp_r;
  int lat;

  initial begin
    vecs[0] = '{8'd0, 8'd2, 8'd4, 8'd6, 8'd1, 8'd3, 8'd5, 8'd7, 8'hFE, 8'd4, 8'hFE, 8'd42, 4'b0000};
    vecs[1] = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 4'b0000};
    vecs[2] = '{8'd0, 8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'hFF, 8'd0, 4'b0000};
    vecs[3] = '{8'd100, 8'd0, 8'd0, 8'd16, 8'd0, 8'd100, 8'd0, 8'd8, 8'd0, 8'd0, 8'h10, 8'h80, 4'b1100};
    vecs[4] = '{8'd0, 8'h80, 8'd0, 8'd0, 8'd0, 8'd0, 8'h80, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 4'b0001};

    rst = 1'b1; start = 1'b0;
    drive(8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9);
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {busy, done, ovf, c4, c3, c2, c1}, 38'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      drive(vecs[i].a1, vecs[i].a2, vecs[i].a3, vecs[i].a4,
            vecs[i].b1, vecs[i].b2, vecs[i].b3, vecs[i].b4);
      launch_and_wait(lat);
      check($sformatf("vec%0d_latency", i), 36'(lat), 36'd8);
      check($sformatf("vec%0d_busy", i), {35'd0, busy}, 36'd0);
      check($sformatf("vec%0d_result", i), outs(),
            {vecs[i].ovf, vecs[i].c4, vecs[i].c3, vecs[i].c2, vecs[i].c1});
      @(posedge clk); #1;
    end

    // Hold after completion: done drops, results stay
    repeat (3) @(posedge clk);
    #1;
    check("hold_done_low", {35'd0, done}, 36'd0);
    check("hold_result", outs(), {4'b0001, 32'd0});

    // Random operands, back-to-back: each new start lands in the done cycle
    drive(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
          8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    for (int r = 0; r < 40; r++) begin
      model(int'(a1), int'(a2), int'(a3), int'(a4), int'(b1), int'(b2), int'(b3), int'(b4), exp_r);
      launch_and_wait(lat);
      check($sformatf("rand%0d_latency", r), 36'(lat), 36'd8);
      check($sformatf("rand%0d_result", r), outs(), exp_r);
      drive(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
            8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    end
    @(posedge clk); #1;

    // Second start while busy plus operand changes mid-operation are ignored
    drive(8'd3, 8'd5, 8'hF9, 8'd11, 8'hFC, 8'd6, 8'd2, 8'hF3);
    model(3, 5, -7, 11, -4, 6, 2, -13, exp_r);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    drive(8'd50, 8'd60, 8'd70, 8'd80, 8'd90, 8'd100, 8'd110, 8'd120);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      start = (k == 2);
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
    start = 1'b0;
    check("ignore_start_latency", 36'(lat), 36'd8);
    check("ignore_start_result", outs(), exp_r);
    repeat (12) begin
      @(posedge clk); #1;
      if (done || busy) lat = -2;
    end
    check("ignore_start_no_relaunch", 36'(lat), 36'd8);

    // Reset mid-operation aborts without a done pulse
    drive(8'd7, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_abort_busy", {35'd0, busy}, 36'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_state", {busy, done, ovf, c4, c3, c2, c1}, 38'd0);
    lat = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done || busy) lat = 1;
    end
    check("abort_no_done", 36'(lat), 36'd0);

    // Fresh operation after abort completes normally
    drive(8'd0, 8'd2, 8'd4, 8'd6, 8'd1, 8'd3, 8'd5, 8'd7);
    launch_and_wait(lat);
    check("post_abort_latency", 36'(lat), 36'd8);
    check("post_abort_result", outs(), {4'b0000, 8'd42, 8'hFE, 8'd4, 8'hFE});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
